// File: rtl/matrix_feeder_pkg.sv
// Shared definitions for the matrix feeder: default geometry, FSM encoding
// and the row-major element slice helper.
package matrix_feeder_pkg;

  localparam int N_DEF      = 2;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  // LSB of element [row][col] in a row-major packed n x n matrix of w-bit elements.
  function automatic int elem_lsb(input int row, input int col, input int n, input int w);
    return w * (row * n + col);
  endfunction

endpackage

// File: rtl/matrix_feeder_skew_lane_select.sv
// One skewed lane: lane LANE presents element (t - LANE) of its N candidate
// elements while that index lies in 0..N-1, otherwise zero.
module skew_lane_select
  import matrix_feeder_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 2,
  parameter int LANE   = 0
) (
  input  logic [CNT_W-1:0]    t,
  input  logic                en,
  input  logic [N*DATA_W-1:0] elems,
  output logic [DATA_W-1:0]   elem
);

  // Pick the element whose skewed slot matches the current step; zero outside the diagonal band.
  always_comb begin
    elem = '0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        if (int'(t) == LANE + k) elem = elems[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/matrix_feeder.sv
// Feeds one C = A x B job into a systolic array: captures both operands,
// clears the accumulators, streams skewed A columns / B rows, drains the
// pipeline with zeros and pulses the result read.
//
// state | meaning
// IDLE  | ready for a job; operands captured on i_load
// CLEAR | one-cycle accumulator clear
// FEED  | 2N-1 skewed operand steps, t = 0..2N-2
// DRAIN | N cycles of zero vectors to flush the array
// READ  | one-cycle result read pulse
module matrix_feeder
  import matrix_feeder_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic [N*N*DATA_W-1:0] i_a_matrix,
  input  logic [N*N*DATA_W-1:0] i_b_matrix,
  input  logic                  i_load,
  output logic                  o_ready,
  output logic [N*DATA_W-1:0]   o_a_vector,
  output logic [N*DATA_W-1:0]   o_b_vector,
  output logic                  o_data_valid,
  output logic                  o_acc_clear,
  output logic                  o_read_en
);

  localparam int CNT_W = $clog2(2 * N);
  // FEED counts t upward; DRAIN reuses the counter as a down-counter to zero.
  localparam logic [CNT_W-1:0] FEED_LAST   = CNT_W'(2 * N - 2);
  localparam logic [CNT_W-1:0] DRAIN_FIRST = CNT_W'(N - 1);

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic                    capture;
  logic [N*N*DATA_W-1:0]   a_reg, b_reg;

  logic [N*DATA_W-1:0]     a_rows [N];
  logic [N*DATA_W-1:0]     b_cols [N];
  logic [N*DATA_W-1:0]     a_vec_nx, b_vec_nx;
  logic                    feed_nx;
  logic                    ready_nx, valid_nx, clear_nx, read_nx;

  // Lane i of A walks row i; lane j of B walks column j (gathered from row-major storage).
  for (genvar i = 0; i < N; i++) begin : g_lanes
    assign a_rows[i] = a_reg[elem_lsb(i, 0, N, DATA_W) +: N*DATA_W];
    for (genvar k = 0; k < N; k++) begin : g_bcol
      assign b_cols[i][k*DATA_W +: DATA_W] = b_reg[elem_lsb(k, i, N, DATA_W) +: DATA_W];
    end

    skew_lane_select #(.N(N), .DATA_W(DATA_W), .CNT_W(CNT_W), .LANE(i)) u_a_lane (
      .t     (cnt_nx),
      .en    (feed_nx),
      .elems (a_rows[i]),
      .elem  (a_vec_nx[i*DATA_W +: DATA_W])
    );

    skew_lane_select #(.N(N), .DATA_W(DATA_W), .CNT_W(CNT_W), .LANE(i)) u_b_lane (
      .t     (cnt_nx),
      .en    (feed_nx),
      .elems (b_cols[i]),
      .elem  (b_vec_nx[i*DATA_W +: DATA_W])
    );
  end

  // State, step counter, operand capture and registered outputs.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      o_ready      <= 1'b1;
      o_data_valid <= 1'b0;
      o_acc_clear  <= 1'b0;
      o_read_en    <= 1'b0;
      o_a_vector   <= '0;
      o_b_vector   <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      if (capture) begin
        a_reg <= i_a_matrix;
        b_reg <= i_b_matrix;
      end
      o_ready      <= ready_nx;
      o_data_valid <= valid_nx;
      o_acc_clear  <= clear_nx;
      o_read_en    <= read_nx;
      o_a_vector   <= a_vec_nx;
      o_b_vector   <= b_vec_nx;
    end
  end

  // Phase sequencing with terminal-count compares on the shared counter.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_load) begin
          state_nx = ST_CLEAR;
          cnt_nx   = '0;
          capture  = 1'b1;
        end
      end
      ST_CLEAR: begin
        state_nx = ST_FEED;
        cnt_nx   = '0;
      end
      ST_FEED: begin
        if (cnt == FEED_LAST) begin
          state_nx = ST_DRAIN;
          cnt_nx   = DRAIN_FIRST;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt == '0) state_nx = ST_READ;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
      ST_READ: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Output values for the upcoming state, so the outputs themselves are flops.
  always_comb begin
    ready_nx = 1'b0;
    valid_nx = 1'b0;
    clear_nx = 1'b0;
    read_nx  = 1'b0;
    feed_nx  = 1'b0;
    unique case (state_nx)
      ST_IDLE:  ready_nx = 1'b1;
      ST_CLEAR: clear_nx = 1'b1;
      ST_FEED: begin
        valid_nx = 1'b1;
        feed_nx  = 1'b1;
      end
      ST_DRAIN: valid_nx = 1'b1;
      ST_READ:  read_nx  = 1'b1;
      default:  ready_nx = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_matrix_feeder.sv
// Bench for matrix_feeder (N=2, 8-bit): phase-counting reference model
// checked every cycle, plus hand-computed literal sequences.
module tb_matrix_feeder;

  localparam int N    = 2;
  localparam int W    = 8;
  localparam int LAST = 3 * N + 1;

  logic             clk = 1'b0;
  logic             i_reset;
  logic             i_load;
  logic [N*N*W-1:0] i_a_matrix, i_b_matrix;
  logic             o_ready, o_data_valid, o_acc_clear, o_read_en;
  logic [N*W-1:0]   o_a_vector, o_b_vector;

  always #5 clk = ~clk;

  matrix_feeder #(.N(N), .DATA_W(W)) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_a_matrix   (i_a_matrix),
    .i_b_matrix   (i_b_matrix),
    .i_load       (i_load),
    .o_ready      (o_ready),
    .o_a_vector   (o_a_vector),
    .o_b_vector   (o_b_vector),
    .o_data_valid (o_data_valid),
    .o_acc_clear  (o_acc_clear),
    .o_read_en    (o_read_en)
  );

  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  // Model: phase 0 = idle, phase p = p cycles after acceptance (1..3N+1).
  int         m_phase = 0;
  logic [W-1:0] m_a [N][N];
  logic [W-1:0] m_b [N][N];

  always @(posedge clk) begin
    if (!i_reset) begin
      m_phase <= 0;
    end else if (m_phase == 0) begin
      if (i_load) begin
        for (int i = 0; i < N; i++)
          for (int k = 0; k < N; k++) begin
            m_a[i][k] <= i_a_matrix[W*(i*N+k) +: W];
            m_b[i][k] <= i_b_matrix[W*(i*N+k) +: W];
          end
        m_phase <= 1;
      end
    end else if (m_phase == LAST) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  function automatic logic [N*W-1:0] exp_a(input int phase);
    logic [N*W-1:0] v;
    int t;
    v = '0;
    if (phase >= 2 && phase <= 2*N) begin
      t = phase - 2;
      for (int i = 0; i < N; i++)
        if (t - i >= 0 && t - i < N) v[i*W +: W] = m_a[i][t-i];
    end
    return v;
  endfunction

  function automatic logic [N*W-1:0] exp_b(input int phase);
    logic [N*W-1:0] v;
    int t;
    v = '0;
    if (phase >= 2 && phase <= 2*N) begin
      t = phase - 2;
      for (int j = 0; j < N; j++)
        if (t - j >= 0 && t - j < N) v[j*W +: W] = m_b[t-j][j];
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready", 64'(o_ready),      64'(m_phase == 0));
      chk("m_clear", 64'(o_acc_clear),  64'(m_phase == 1));
      chk("m_valid", 64'(o_data_valid), 64'(m_phase >= 2 && m_phase <= 3*N));
      chk("m_read",  64'(o_read_en),    64'(m_phase == LAST));
      chk("m_avec",  64'(o_a_vector),   64'(exp_a(m_phase)));
      chk("m_bvec",  64'(o_b_vector),   64'(exp_b(m_phase)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One-pulse job with fully hand-computed cycle-by-cycle expectations.
  task automatic run_lit(input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] ea2, input logic [15:0] ea3, input logic [15:0] ea4,
                         input logic [15:0] eb2, input logic [15:0] eb3, input logic [15:0] eb4);
    logic [15:0] ea, eb;
    i_a_matrix = a;
    i_b_matrix = b;
    i_load     = 1'b1;
    tick();
    i_load     = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("lit_clear", 64'(o_acc_clear),  64'(k == 1));
      chk("lit_valid", 64'(o_data_valid), 64'(k >= 2 && k <= 6));
      chk("lit_read",  64'(o_read_en),    64'(k == 7));
      chk("lit_ready", 64'(o_ready),      64'(k == 8));
      case (k)
        2:       begin ea = ea2; eb = eb2; end
        3:       begin ea = ea3; eb = eb3; end
        4:       begin ea = ea4; eb = eb4; end
        default: begin ea = 16'h0000; eb = 16'h0000; end
      endcase
      chk("lit_avec", 64'(o_a_vector), 64'(ea));
      chk("lit_bvec", 64'(o_b_vector), 64'(eb));
    end
  endtask

  initial begin
    i_reset    = 1'b0;
    i_load     = 1'b0;
    i_a_matrix = '0;
    i_b_matrix = '0;
    tick();
    tick();
    i_reset = 1'b1;
    chk_en  = 1'b1;

    @(negedge clk);
    chk("rst_ready", 64'(o_ready),      64'd1);
    chk("rst_valid", 64'(o_data_valid), 64'd0);
    chk("rst_avec",  64'(o_a_vector),   64'd0);
    tick();

    // Reference job: A=(1,2;3,4), B=(5,6;7,8).
    run_lit(32'h04030201, 32'h08070605,
            16'h0001, 16'h0302, 16'h0400, 16'h0005, 16'h0607, 16'h0800);
    tick();

    // -128 everywhere must pass through untouched.
    run_lit(32'h80808080, 32'h80808080,
            16'h0080, 16'h8080, 16'h8000, 16'h0080, 16'h8080, 16'h8000);
    tick();

    // i_load held high: back-to-back jobs; inputs change after first acceptance.
    i_a_matrix = 32'h04030201;
    i_b_matrix = 32'h08070605;
    i_load     = 1'b1;
    tick();
    i_a_matrix = 32'h11223344;
    i_b_matrix = 32'hA0B0C0D0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 3) chk("b2b_job1_a", 64'(o_a_vector), 64'h0302);
      if (k == 7) chk("b2b_read",   64'(o_read_en),  64'd1);
      if (k == 8) chk("b2b_ready",  64'(o_ready),    64'd1);
      if (k == 9) chk("b2b_clear2", 64'(o_acc_clear), 64'd1);
      if (k >= 7) chk("b2b_gap_valid", 64'(o_data_valid), 64'd0);
    end
    i_load = 1'b0;
    repeat (10) tick();

    // i_load pulsed during FEED with other operands must be ignored.
    i_a_matrix = 32'h04030201;
    i_b_matrix = 32'h08070605;
    i_load     = 1'b1;
    tick();
    i_load     = 1'b0;
    tick();
    i_a_matrix = 32'hDEADBEEF;
    i_b_matrix = 32'h5A5AA5A5;
    i_load     = 1'b1;
    tick();
    i_load     = 1'b0;
    @(negedge clk);
    chk("feedload_a", 64'(o_a_vector), 64'h0302);
    chk("feedload_b", 64'(o_b_vector), 64'h0607);
    repeat (12) tick();

    // Reset for one cycle in DRAIN aborts the job; i_load during reset ignored.
    i_a_matrix = 32'h7F80FF01;
    i_b_matrix = 32'h02FE8103;
    i_load     = 1'b1;
    tick();
    i_load     = 1'b0;
    repeat (4) tick();
    chk("pre_rst_drain", 64'(o_data_valid), 64'd1);
    i_reset = 1'b0;
    i_load  = 1'b1;
    tick();
    i_reset = 1'b1;
    i_load  = 1'b0;
    @(negedge clk);
    chk("abort_ready", 64'(o_ready),      64'd1);
    chk("abort_valid", 64'(o_data_valid), 64'd0);
    chk("abort_avec",  64'(o_a_vector),   64'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_read", 64'(o_read_en), 64'd0);
    end
    tick();

    // A mixed-sign job checked by the model alone.
    i_a_matrix = 32'hC3017FFE;
    i_b_matrix = 32'h3C9A0280;
    i_load     = 1'b1;
    tick();
    i_load     = 1'b0;
    repeat (10) tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_feeder.md
MATRIX_FEEDER -- requirements
Module: matrix_feeder

Interface
REQ-001 Parameter N, default 2: array dimension (N x N operands, N lanes per vector).
REQ-002 Parameter DATA_W, default 8: signed operand element width.
REQ-003 clk  in  1  single clock; all logic updates on rising edge.
REQ-004 i_reset  in  1  reset, synchronous and active-low.
REQ-005 i_a_matrix  in  N*N*DATA_W  A operand, row-major; A[i][k] at bits [DATA_W*(i*N+k) +: DATA_W].
REQ-006 i_b_matrix  in  N*N*DATA_W  B operand, row-major; B[k][j] at bits [DATA_W*(k*N+j) +: DATA_W].
REQ-007 i_load  in  1  request to start one C = A x B job.
REQ-008 o_ready  out  1  feeder idle; job accepted on an edge where i_load & o_ready.
REQ-009 o_a_vector  out  N*DATA_W  skewed A column to array; lane i = row i.
REQ-010 o_b_vector  out  N*DATA_W  skewed B row to array; lane j = column j.
REQ-011 o_data_valid  out  1  drives the array's i_data_valid.
REQ-012 o_acc_clear  out  1  one-cycle accumulator-clear pulse to the array.
REQ-013 o_read_en  out  1  drives the array's i_read_en; one-cycle pulse marking result ready.

Function
REQ-014 FSM states: IDLE, CLEAR, FEED, DRAIN, READ; all outputs registered.
REQ-015 IDLE: o_ready=1, other outputs 0; on i_load, capture both matrices into internal registers and enter CLEAR.
REQ-016 CLEAR: exactly 1 cycle, o_acc_clear=1, o_data_valid=0, vectors 0; then FEED with step counter t=0.
REQ-017 FEED: 2N-1 cycles, o_data_valid=1; lane i of o_a_vector = A[i][t-i] when 0<=t-i<N, else 0; lane j of o_b_vector = B[t-j][j] when 0<=t-j<N, else 0.
REQ-018 DRAIN: N cycles, o_data_valid=1, both vectors all-zero, to flush the systolic pipeline.
REQ-019 READ: 1 cycle, o_read_en=1, o_data_valid=0, vectors 0; then IDLE.
REQ-020 Latency: with acceptance edge as cycle 0, CLEAR in cycle 1, FEED cycles 2..2N, DRAIN cycles 2N+1..3N, READ cycle 3N+1, o_ready=1 from cycle 3N+2.
REQ-021 i_load while o_ready=0 is ignored; captured operands are not altered until next acceptance.
REQ-022 Input matrix changes after acceptance do not affect the running job.
REQ-023 Elements are passed bit-exact; no arithmetic, sign extension or saturation in this block.
REQ-024 i_load asserted in READ cycle is not accepted; accepted only in a cycle where o_ready=1.

Reset
REQ-025 i_reset=0 at a rising edge forces IDLE, o_ready=1, o_data_valid=0, o_acc_clear=0, o_read_en=0, vectors 0, step counter 0, operand registers 0.
REQ-026 Reset mid-job aborts it: no o_read_en issued for the aborted job; i_load ignored while i_reset=0.

Structure
REQ-027 Shared package holds N, DATA_W defaults, FSM state encoding and element-slice helper constants.
REQ-028 One sub-module, skew_lane_select, computes a single lane's element/zero from step t and lane index; instantiated 2N times.

Verification
REQ-029 N=2; A=32'h04030201 (1,2;3,4), B=32'h08070605 (5,6;7,8), i_load pulse -> cycle1 o_acc_clear=1; FEED a/b = 0001/0005, 0302/0607, 0400/0800; DRAIN 2 cycles 0000/0000 valid=1; o_read_en=1 cycle 7; o_ready=1 cycle 8.
REQ-030 Same job driven into processing_array -> o_c_matrix holds C = 19,22,43,50, o_saturate_detect=0.
REQ-031 i_load held high continuously -> back-to-back jobs, second accepted in cycle 8, no overlap of o_data_valid between jobs.
REQ-032 i_load pulsed in FEED with different matrices -> ignored; vectors match first job exactly.
REQ-033 i_reset=0 for 1 cycle in DRAIN -> next cycle IDLE, all outputs 0, o_ready=1, no o_read_en.
REQ-034 A=B=all 8'h80 (-128) -> vectors carry 8'h80 unchanged in every non-zero lane.
